mem_port_sched: RTL and testbench
=================================

Name: mem_port_sched

Overview:
- Scheduler that shares one single-port, 16-bit-wide synchronous RAM between three requesters: CPU instruction fetch, CPU data read and CPU data write.
- Memory is byte-addressed, little-endian, one-cycle read latency.
- Fetch returns a 24-bit instruction that always takes two word reads; data reads and writes take one word access, or two when misaligned.
- Arbitration is fixed priority: write, then read, then fetch. A starvation guard forces fetch through after a bounded run of data transactions.

Parameters:
- STARVE_LIMIT, 4: number of consecutive data transactions granted while f_req is pending; after that many, fetch wins the next arbitration.

Ports:
- clk  input  1  clock, all logic on posedge.
- reset  input  1  synchronous, active-low reset; logic is reset when reset==0 at posedge.
- f_req  input  1  fetch request; held until f_done.
- f_addr  input  16  fetch byte address.
- f_data  output  24  fetched bytes {A+2, A+1, A}.
- f_done  output  1  one-cycle completion pulse.
- r_req  input  1  data read request; held until r_done.
- r_addr  input  16  read byte address.
- r_data  output  16  {byte A+1, byte A}.
- r_done  output  1  one-cycle completion pulse.
- w_req  input  1  write request; held until w_done.
- w_addr  input  16  write byte address.
- w_data  input  16  write data; low byte goes to address A.
- w_be  input  2  byte enables; bit0 = byte A, bit1 = byte A+1.
- w_done  output  1  one-cycle completion pulse.
- mem_en  output  1  RAM access strobe.
- mem_we  output  1  RAM write.
- mem_be  output  2  RAM lane enables.
- mem_addr  output  15  RAM word address.
- mem_wdata  output  16  RAM write data.
- mem_rdata  input  16  RAM read data; valid the cycle after mem_en with mem_we=0.
- busy  output  1  high when state != IDLE.

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE; starve counter=0.
  - All done outputs, f_data, r_data, mem_en, mem_we, mem_be, mem_addr and mem_wdata = 0.
  - An in-flight transaction is aborted with no done pulse. A request still held is re-arbitrated after reset.
- States:
  - IDLE: pick the winner. Latch its address, data, byte enables and kind, and compute the split flag. Go to ACC0. If no request, stay in IDLE.
  - ACC0: mem_en=1 for word0 = addr[15:1]. Next state: ACC1 if split; else WAIT for a read; else DONE.
  - ACC1: mem_en=1 for word1 = word0+1, modulo 2^15 (0x7FFF+1 -> 0x0000). Capture word0 read data. Next state: WAIT for a read, DONE for a write.
  - WAIT: capture the last read data; next state DONE.
  - DONE: pulse the owner's done for exactly 1 cycle; next state IDLE.
- mem_* outputs are driven from registered state. In IDLE, WAIT and DONE: mem_en=0 and mem_we=0.
- Latency, with the request sampled in IDLE at cycle t:
  - Aligned write: done at t+2.
  - Split write: done at t+3.
  - Aligned read: done at t+3.
  - Split read and any fetch: done at t+4.
- Split rules:
  - Fetch is always split.
  - A read is split when addr[0]=1.
  - A write is split only when addr[0]=1 and w_be=11.
- Odd-address writes that are not split:
  - be=01: word0, mem_be=10, byte in the high lane.
  - be=10: word1, mem_be=01, byte in the low lane.
  - be=00: no memory access; go IDLE -> DONE, still pulse w_done.
- Split write lane mapping:
  - word0: mem_be=10, mem_wdata[15:8]=w_data[7:0].
  - word1: mem_be=01, mem_wdata[7:0]=w_data[15:8].
- Even-address writes: a single access with mem_be=w_be.
- Fetch assembly:
  - Even A: {w1[7:0], w0[15:8], w0[7:0]}.
  - Odd A: {w1[15:8], w1[7:0], w0[15:8]}.
- Data read assembly:
  - Even A: w0.
  - Odd A: {w1[7:0], w0[15:8]}.
- Output hold: f_data and r_data update only in their DONE cycle and hold until the next completion for that port.
- Arbitration:
  - Priority is w > r > f.
  - If f_req is pending and starve counter == STARVE_LIMIT, fetch wins.
  - The counter increments, saturating, on each data grant while f_req=1.
  - The counter clears on a fetch grant or when f_req=0.
- Done-cycle handshake:
  - A requester may drop or change its request in the cycle after its done.
  - The scheduler does not arbitrate during DONE, so a stale held request is never double-served.
  - Address and data inputs are ignored outside the IDLE latch cycle.

Test Plan:
- Aligned read: RAM[word 0x0010]=0xBEEF; r_req with r_addr=0x0020 -> one access, mem_addr=0x0010; r_done at t+3 with r_data=0xBEEF.
- Misaligned fetch: RAM words 0x0000=0x2211 and 0x0001=0x4433; f_addr=0x0001 -> two accesses; f_done at t+4 with f_data=0x443322.
- Split write: w_addr=0x0005, w_be=11, w_data=0xA1B2 -> word 0x0002 gets be=10 and hi=0xB2, then word 0x0003 gets be=01 and lo=0xA1; w_done at t+3.
- Wrap: r_addr=0xFFFF -> accesses to words 0x7FFF then 0x0000; r_data={RAM[0][7:0], RAM[0x7FFF][15:8]}.
- Priority and starvation, STARVE_LIMIT=4: f_req, r_req and w_req all held continuously -> write first, then data grants; fetch is granted on the 5th arbitration; the counter then clears.
- Reset mid-split-read: reset=0 during ACC1 -> no r_done, mem_en=0, busy=0 next cycle; the held r_req completes normally after reset=1.

Source files
------------

// File: rtl/mem_port_sched.sv
// Shares one single-port 16-bit synchronous RAM between instruction fetch, data read and data write.
// Byte-addressed little-endian front end; misaligned accesses are split into two word accesses.
module mem_port_sched #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        f_req,
    input  logic [15:0] f_addr,
    output logic [23:0] f_data,
    output logic        f_done,
    input  logic        r_req,
    input  logic [15:0] r_addr,
    output logic [15:0] r_data,
    output logic        r_done,
    input  logic        w_req,
    input  logic [15:0] w_addr,
    input  logic [15:0] w_data,
    input  logic [1:0]  w_be,
    output logic        w_done,
    output logic        mem_en,
    output logic        mem_we,
    output logic [1:0]  mem_be,
    output logic [14:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        busy
);
    localparam int CW = $clog2(STARVE_LIMIT + 2);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic [2:0] {IDLE, ACC0, ACC1, WAIT, DONE} state_t;
    typedef enum logic [1:0] {K_F, K_R, K_W} kind_t;

    state_t        state_q, state_d;
    kind_t         kind_q, kind_d;
    logic [15:0]   addr_q, addr_d;
    logic [15:0]   wdata_q, wdata_d;
    logic [1:0]    be_q, be_d;
    logic          split_q, split_d;
    logic [15:0]   w0_q, w0_d;
    logic [23:0]   f_data_q, f_data_d;
    logic [15:0]   r_data_q, r_data_d;
    logic [CW-1:0] starve_q, starve_d;

    logic          any_req, grant_f, grant_r, grant_w;
    logic [14:0]   word0, word1;

    assign word0 = addr_q[15:1];
    assign word1 = word0 + 15'd1;

    always_comb begin
        any_req = f_req | r_req | w_req;
        grant_f = 1'b0;
        grant_r = 1'b0;
        grant_w = 1'b0;
        if (f_req && starve_q == LIMIT) grant_f = 1'b1;
        else if (w_req)                 grant_w = 1'b1;
        else if (r_req)                 grant_r = 1'b1;
        else if (f_req)                 grant_f = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            kind_q   <= K_F;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            split_q  <= 1'b0;
            w0_q     <= '0;
            f_data_q <= '0;
            r_data_q <= '0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            kind_q   <= kind_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            split_q  <= split_d;
            w0_q     <= w0_d;
            f_data_q <= f_data_d;
            r_data_q <= r_data_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        kind_d   = kind_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        split_d  = split_q;
        w0_d     = w0_q;
        f_data_d = f_data_q;
        r_data_d = r_data_q;
        starve_d = starve_q;
        case (state_q)
            IDLE: if (any_req) begin
                if (grant_w) begin
                    kind_d  = K_W;
                    addr_d  = w_addr;
                    wdata_d = w_data;
                    be_d    = w_be;
                    split_d = w_addr[0] & (w_be == 2'b11);
                end else if (grant_r) begin
                    kind_d  = K_R;
                    addr_d  = r_addr;
                    split_d = r_addr[0];
                end else begin
                    kind_d  = K_F;
                    addr_d  = f_addr;
                    split_d = 1'b1;
                end
                // An odd-address write with no lanes enabled touches no word at all.
                state_d = (grant_w && w_addr[0] && w_be == 2'b00) ? DONE : ACC0;
                if (grant_f)                        starve_d = '0;
                else if (f_req && starve_q != LIMIT) starve_d = starve_q + CW'(1);
            end
            ACC0: state_d = split_q ? ACC1 : ((kind_q == K_R) ? WAIT : DONE);
            ACC1: begin
                w0_d    = mem_rdata;
                state_d = (kind_q == K_W) ? DONE : WAIT;
            end
            WAIT: begin
                state_d = DONE;
                if (kind_q == K_F)
                    f_data_d = addr_q[0] ? {mem_rdata, w0_q[15:8]} : {mem_rdata[7:0], w0_q};
                else
                    r_data_d = addr_q[0] ? {mem_rdata[7:0], w0_q[15:8]} : mem_rdata;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (!f_req) starve_d = '0;
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 2'b00;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state_q == ACC0 || state_q == ACC1) begin
            mem_en = 1'b1;
            mem_we = (kind_q == K_W);
            if (kind_q != K_W) begin
                mem_be   = 2'b11;
                mem_addr = (state_q == ACC0) ? word0 : word1;
            end else if (!addr_q[0]) begin
                mem_be    = be_q;
                mem_addr  = word0;
                mem_wdata = wdata_q;
            end else begin
                // Odd address: byte A sits in word0's high lane, byte A+1 in word1's low lane.
                mem_wdata = {wdata_q[7:0], wdata_q[15:8]};
                if (state_q == ACC1 || (!split_q && be_q == 2'b10)) begin
                    mem_addr = word1;
                    mem_be   = 2'b01;
                end else begin
                    mem_addr = word0;
                    mem_be   = 2'b10;
                end
            end
        end
        f_done = (state_q == DONE) && (kind_q == K_F);
        r_done = (state_q == DONE) && (kind_q == K_R);
        w_done = (state_q == DONE) && (kind_q == K_W);
        busy   = (state_q != IDLE);
        f_data = f_data_q;
        r_data = r_data_q;
    end
endmodule

// File: tb/tb_mem_port_sched.sv
// Bench for mem_port_sched: byte-level shadow memory plus a transaction-level timing model,
// directed scenarios with literal expectations, then randomized requesters.
module tb_mem_port_sched;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        f_req = 1'b0;
    logic [15:0] f_addr = '0;
    logic [23:0] f_data;
    logic        f_done;
    logic        r_req = 1'b0;
    logic [15:0] r_addr = '0;
    logic [15:0] r_data;
    logic        r_done;
    logic        w_req = 1'b0;
    logic [15:0] w_addr = '0;
    logic [15:0] w_data = '0;
    logic [1:0]  w_be = '0;
    logic        w_done;
    logic        mem_en, mem_we;
    logic [1:0]  mem_be;
    logic [14:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        busy;

    always #5 clk = ~clk;

    mem_port_sched #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_data(f_data), .f_done(f_done),
        .r_req(r_req), .r_addr(r_addr), .r_data(r_data), .r_done(r_done),
        .w_req(w_req), .w_addr(w_addr), .w_data(w_data), .w_be(w_be), .w_done(w_done),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    logic [15:0] ram [0:32767];
    logic [7:0]  sh  [0:65535];

    always @(posedge clk) begin
        if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
        if (mem_en && mem_we) begin
            if (mem_be[0]) ram[mem_addr][7:0]  = mem_wdata[7:0];
            if (mem_be[1]) ram[mem_addr][15:8] = mem_wdata[15:8];
        end
    end

    int checks = 0, errors = 0, cyc = 0;
    int next_arb = 1 << 30, cnt = 0;
    int done_at[3];
    int busy_lo = -1, busy_hi = -1;
    int acc_cnt = 0, exp_acc = 0, cur_kind = 0;
    logic [23:0] exp_f = '0, pend_f = '0;
    logic [15:0] exp_r = '0, pend_r = '0;
    bit seen_done[3];
    bit outst[3];
    bit auto_drv = 1'b0, draining = 1'b0;
    int done_log[$];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", nm, cyc, got, exp);
        end
    endtask

    task automatic poke(input logic [14:0] w, input logic [15:0] v);
        ram[w] = v;
        sh[{w, 1'b0}] = v[7:0];
        sh[{w, 1'b1}] = v[15:8];
    endtask

    function automatic logic [15:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) return 16'hFFF8 + 16'($urandom_range(0, 7));
        return 16'($urandom_range(0, 63));
    endfunction

    // One clock: apply the transaction model to what the edge sampled, then compare.
    task automatic step();
        logic sf, sr, sw, srst;
        logic [15:0] fa, ra, wa, wd, a, a1, a2;
        logic [1:0] wb;
        int win, lat;
        bit any_exp;
        sf = f_req; sr = r_req; sw = w_req; srst = reset;
        fa = f_addr; ra = r_addr; wa = w_addr; wd = w_data; wb = w_be;
        @(posedge clk);
        #1;
        cyc++;
        if (!srst) begin
            cnt = 0;
            done_at = '{-1, -1, -1};
            busy_lo = -1; busy_hi = -1;
            exp_f = '0; exp_r = '0;
            acc_cnt = 0;
            next_arb = cyc + 1;
        end else begin
            if (cyc >= next_arb && (sf || sr || sw)) begin
                if (sf && cnt == LIMIT) win = 0;
                else if (sw)            win = 2;
                else if (sr)            win = 1;
                else                    win = 0;
                if (win == 0) cnt = 0;
                else if (sf && cnt < LIMIT) cnt++;
                lat = 2;
                if (win == 0) begin
                    a = fa; a1 = a + 16'd1; a2 = a + 16'd2;
                    lat = 4; exp_acc = 2;
                    pend_f = {sh[a2], sh[a1], sh[a]};
                end else if (win == 1) begin
                    a = ra; a1 = a + 16'd1;
                    lat = ra[0] ? 4 : 3; exp_acc = ra[0] ? 2 : 1;
                    pend_r = {sh[a1], sh[a]};
                end else begin
                    a = wa; a1 = a + 16'd1;
                    if (!wa[0])          begin lat = 2; exp_acc = 1; end
                    else if (wb == 2'b11) begin lat = 3; exp_acc = 2; end
                    else if (wb == 2'b00) begin lat = 1; exp_acc = 0; end
                    else                  begin lat = 2; exp_acc = 1; end
                    if (wb[0]) sh[a]  = wd[7:0];
                    if (wb[1]) sh[a1] = wd[15:8];
                end
                done_at[win] = cyc + lat - 1;
                busy_lo = cyc; busy_hi = cyc + lat - 1;
                next_arb = cyc + lat + 1;
                cur_kind = win;
                acc_cnt = 0;
            end
            if (!sf) cnt = 0;
        end
        if (mem_en) begin
            acc_cnt++;
            chk("mem_we", mem_we, cur_kind == 2);
        end
        chk("busy", busy, cyc >= busy_lo && cyc <= busy_hi);
        if (!(cyc >= busy_lo && cyc <= busy_hi)) chk("mem_en_idle", mem_en, 0);
        chk("f_done", f_done, done_at[0] == cyc);
        chk("r_done", r_done, done_at[1] == cyc);
        chk("w_done", w_done, done_at[2] == cyc);
        any_exp = (done_at[0] == cyc) || (done_at[1] == cyc) || (done_at[2] == cyc);
        if (done_at[0] == cyc) exp_f = pend_f;
        if (done_at[1] == cyc) exp_r = pend_r;
        if (any_exp) chk("accesses", acc_cnt, exp_acc);
        chk("f_data", f_data, exp_f);
        chk("r_data", r_data, exp_r);
        seen_done[0] = f_done; seen_done[1] = r_done; seen_done[2] = w_done;
        for (int p = 0; p < 3; p++) if (seen_done[p]) done_log.push_back(p);
        if (auto_drv) begin
            for (int p = 0; p < 3; p++) if (seen_done[p]) outst[p] = 1'b0;
            if (!outst[0]) begin
                if (!draining && $urandom_range(0, 2) == 0) begin
                    f_req = 1'b1; f_addr = rnd_addr(); outst[0] = 1'b1;
                end else f_req = 1'b0;
            end
            if (!outst[1]) begin
                if (!draining && $urandom_range(0, 2) == 0) begin
                    r_req = 1'b1; r_addr = rnd_addr(); outst[1] = 1'b1;
                end else r_req = 1'b0;
            end
            if (!outst[2]) begin
                if (!draining && $urandom_range(0, 2) == 0) begin
                    w_req = 1'b1; w_addr = rnd_addr(); w_data = 16'($urandom());
                    w_be = 2'($urandom_range(0, 3)); outst[2] = 1'b1;
                end else w_req = 1'b0;
            end
        end
    endtask

    task automatic wait_done(input int p, input int maxc, input string nm);
        int n;
        n = 0;
        while (!seen_done[p] && n < maxc) begin
            step();
            n++;
        end
        if (!seen_done[p]) begin
            checks++; errors++;
            $display("FAIL %s timeout after %0d cycles", nm, maxc);
        end
    endtask

    initial begin
        int t, bad, n;
        int exp_seq[6];
        exp_seq = '{2, 2, 2, 2, 0, 2};
        done_at = '{-1, -1, -1};
        for (int i = 0; i < 32768; i++) poke(15'(i), 16'(i * 40503) ^ 16'h5A5A);

        step(); step();
        chk("rst_busy", busy, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_be", mem_be, 0);
        chk("rst_f_data", f_data, 0);
        chk("rst_r_data", r_data, 0);
        reset = 1'b1;
        step();

        // aligned read
        poke(15'h0010, 16'hBEEF);
        r_req = 1'b1; r_addr = 16'h0020;
        step(); t = cyc;
        chk("rd_mem_addr", mem_addr, 15'h0010);
        chk("rd_mem_en", mem_en, 1);
        wait_done(1, 10, "rd_done");
        chk("rd_latency", cyc - t, 2);
        chk("rd_data", r_data, 16'hBEEF);
        r_req = 1'b0; step(); step();

        // misaligned fetch
        poke(15'h0000, 16'h2211); poke(15'h0001, 16'h4433);
        f_req = 1'b1; f_addr = 16'h0001;
        step(); t = cyc;
        chk("f_word0", mem_addr, 15'h0000);
        step();
        chk("f_word1", mem_addr, 15'h0001);
        wait_done(0, 10, "f_done");
        chk("f_latency", cyc - t, 3);
        chk("f_data_lit", f_data, 24'h443322);
        f_req = 1'b0; step(); step();

        // split write
        w_req = 1'b1; w_addr = 16'h0005; w_be = 2'b11; w_data = 16'hA1B2;
        step(); t = cyc;
        chk("sw0_addr", mem_addr, 15'h0002);
        chk("sw0_be", mem_be, 2'b10);
        chk("sw0_hi", mem_wdata[15:8], 8'hB2);
        step();
        chk("sw1_addr", mem_addr, 15'h0003);
        chk("sw1_be", mem_be, 2'b01);
        chk("sw1_lo", mem_wdata[7:0], 8'hA1);
        wait_done(2, 10, "sw_done");
        chk("sw_latency", cyc - t, 2);
        chk("sw_ram2_hi", ram[2][15:8], 8'hB2);
        chk("sw_ram3_lo", ram[3][7:0], 8'hA1);
        w_req = 1'b0; step(); step();

        // wrap across the top of memory
        poke(15'h0000, 16'h5566); poke(15'h7FFF, 16'h77AB);
        r_req = 1'b1; r_addr = 16'hFFFF;
        step();
        chk("wrap_w0", mem_addr, 15'h7FFF);
        step();
        chk("wrap_w1", mem_addr, 15'h0000);
        wait_done(1, 10, "wrap_done");
        chk("wrap_data", r_data, 16'h6677);
        r_req = 1'b0; step(); step();

        // all three held: fetch must break through after LIMIT data grants
        done_log.delete();
        w_req = 1'b1; w_addr = 16'h0040; w_be = 2'b11; w_data = 16'h1234;
        r_req = 1'b1; r_addr = 16'h0042;
        f_req = 1'b1; f_addr = 16'h0044;
        n = 0;
        while (done_log.size() < 6 && n < 80) begin step(); n++; end
        for (int i = 0; i < 6; i++)
            chk("grant_seq", (i < done_log.size()) ? done_log[i] : -1, exp_seq[i]);
        w_req = 1'b0; r_req = 1'b0; f_req = 1'b0;
        n = 0;
        while (busy && n < 10) begin step(); n++; end
        step();

        // reset while a split read is in ACC1
        poke(15'h0008, 16'h1234); poke(15'h0009, 16'h5678);
        r_req = 1'b1; r_addr = 16'h0011;
        step(); step();
        chk("rst_mid_acc1", mem_addr, 15'h0009);
        reset = 1'b0;
        step();
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_en", mem_en, 0);
        chk("rst_mid_done", r_done, 0);
        reset = 1'b1;
        wait_done(1, 10, "rst_retry");
        chk("rst_retry_data", r_data, 16'h7812);
        r_req = 1'b0; step(); step();

        // randomized requesters
        auto_drv = 1'b1;
        for (int i = 0; i < 3000; i++) step();
        draining = 1'b1;
        n = 0;
        while ((outst[0] || outst[1] || outst[2] || busy) && n < 200) begin step(); n++; end
        chk("drain", {29'b0, outst[0], outst[1], outst[2]}, 0);

        bad = 0;
        for (int i = 0; i < 32768; i++)
            if (ram[i] !== {sh[2 * i + 1], sh[2 * i]}) bad++;
        chk("ram_image", bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
